motor_cmd_spi_rx: RTL and testbench
===================================

Name: motor_cmd_spi_rx

Overview:
SPI slave that receives motor commands from the microcontroller running the balance loop and drives the PWM motor controller's command inputs.
- Delivers sign, 7-bit duty per motor, and a one-cycle load strobe on every accepted frame.
- Sits directly upstream of the PWM/H-bridge stage.
- Includes a watchdog that forces both duties to zero if the link goes silent, so a hung MCU cannot leave motors driven.

Parameters:
DUTY_MAX, 100, saturation ceiling for duty fields; matches the PWM stage's counter period.
WDOG_CYCLES, 2_400_000, clk cycles without a valid frame before failsafe (50 ms at 48 MHz).

Ports:
clk  in  1  system clock; must be >= 8x sck frequency.
reset  in  1  synchronous, active-high.
sck  in  1  SPI clock from MCU, async; mode 0, sample on rising edge.
cs_n  in  1  SPI chip select, async, active-low.
sdi  in  1  SPI data (MOSI), MSB first.
motor1_sign  out  1  direction, motor 1.
motor1_upperlimit  out  7  duty 0..DUTY_MAX, motor 1.
motor2_sign  out  1  direction, motor 2.
motor2_upperlimit  out  7  duty 0..DUTY_MAX, motor 2.
load  out  1  one-cycle pulse when any output value is updated.
frame_error  out  1  one-cycle pulse on malformed frame.
wdog_timeout  out  1  level; high while in failsafe.

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high.
- Input sync:
  - sck, cs_n, sdi each pass through a 2-flop synchronizer.
  - sck and cs_n also get a registered previous-value for edge detect.
- Frame format: 16 bits, MSB first.
  - bit15 = motor1_sign, bits14:8 = motor1 duty.
  - bit7 = motor2_sign, bits6:0 = motor2 duty.
- FSM states:
  - IDLE:
    - Synced cs_n falling edge -> RECV; clear shift register and bit count.
    - cs_n held low at reset release does not start a frame; a falling edge is required.
  - RECV:
    - Each synced sck rising edge shifts in synced sdi; bit count saturates at 17.
    - Synced cs_n rising edge -> DONE.
  - DONE (one cycle):
    - bit count == 16: commit. Duty > DUTY_MAX saturates to DUTY_MAX. Update all four outputs; pulse load; restart watchdog; clear wdog_timeout.
    - Any other count: pulse frame_error; outputs, load, and watchdog unchanged.
    - Always -> IDLE.
- Latency: commit outputs and load are visible after the 3rd clk rising edge following the first edge that samples cs_n high.
- Watchdog:
  - Counter increments every cycle when not committing.
  - On reaching WDOG_CYCLES-1: both upperlimits -> 0, signs held, load pulses, wdog_timeout -> 1, counter holds.
  - No further load pulses until a valid frame arrives.
- Simultaneous events:
  - Commit and watchdog expiry in the same cycle: commit wins; counter restarts.
  - Reset mid-frame: frame discarded; FSM -> IDLE.
- Reset values: signs 0, upperlimits 0, load 0, frame_error 0, wdog_timeout 0, watchdog counter 0, FSM IDLE.
- Widths:
  - Watchdog counter is $clog2(WDOG_CYCLES) bits.
  - Bit counter is 5 bits.
  - Saturation compare is 7-bit unsigned.

Decomposition:
- Package motor_cmd_pkg:
  - DUTY_MAX and FRAME_BITS=16.
  - Field bit positions (M1_SIGN_BIT, M1_DUTY_MSB/LSB, M2_...).
  - FSM enum rx_state_t {IDLE, RECV, DONE}.
- Sub-module sync_edge_det: 2-flop sync plus rise/fall pulses. Instantiated for sck and cs_n; sdi uses the sync path only.

Test Plan:
- Valid frame 0x8A_32 -> motor1_sign=1, motor1_upperlimit=10, motor2_sign=0, motor2_upperlimit=50. load high exactly 1 cycle; latency 3 cycles after cs_n rise.
- Frame 0x7F_FF -> both upperlimits saturate to 100; motor1_sign=0, motor2_sign=1; single load pulse.
- 12-bit frame, then 20-bit frame -> frame_error pulses once each. Outputs keep the prior values (10/50), no load, wdog_timeout unchanged.
- WDOG_CYCLES=1000, valid frame then silence -> after 1000 cycles both upperlimits=0, signs held, one load pulse, wdog_timeout=1. A next valid frame 0x0505 clears the flag and gives limits 5/5.
- reset asserted after bit 9 of a frame, with cs_n still low at release -> remaining bits ignored, no load or frame_error. The following full frame 0x8164 commits 1/100 normally.
- cs_n rise commit landing on the same cycle as watchdog expiry -> committed values appear, wdog_timeout stays 0, counter restarts at 0.

Source files
------------

// File: rtl/motor_cmd_pkg.sv
// rtl/motor_cmd_pkg.sv - constants, frame field positions and FSM states for the motor command receiver
package motor_cmd_pkg;

    localparam int DUTY_MAX   = 100;
    localparam int FRAME_BITS = 16;

    // Bit counter stops here so oversized frames stay distinguishable from 16
    localparam logic [4:0] BIT_CNT_SAT = 5'd17;

    localparam int M1_SIGN_BIT = 15;
    localparam int M1_DUTY_MSB = 14;
    localparam int M1_DUTY_LSB = 8;
    localparam int M2_SIGN_BIT = 7;
    localparam int M2_DUTY_MSB = 6;
    localparam int M2_DUTY_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } rx_state_t;

    function automatic logic [6:0] sat_duty(input logic [6:0] duty, input logic [6:0] ceil);
        return (duty > ceil) ? ceil : duty;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with registered previous value and rise/fall pulses
module sync_edge_det (
    input  logic clk,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // No reset: edges only appear when the pin really toggles, so a level held
    // across reset release (e.g. cs_n already low) never looks like an edge.
    always_ff @(posedge clk) begin
        meta <= din;
        sync <= meta;
        prev <= sync;
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/motor_cmd_spi_rx.sv
// rtl/motor_cmd_spi_rx.sv - SPI slave decoding motor command frames with duty saturation and link watchdog
module motor_cmd_spi_rx #(
    parameter int DUTY_MAX    = motor_cmd_pkg::DUTY_MAX,
    parameter int WDOG_CYCLES = 2_400_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       sdi,
    output logic       motor1_sign,
    output logic [6:0] motor1_upperlimit,
    output logic       motor2_sign,
    output logic [6:0] motor2_upperlimit,
    output logic       load,
    output logic       frame_error,
    output logic       wdog_timeout
);
    import motor_cmd_pkg::*;

    localparam int                WDOG_W    = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [6:0]        DUTY_CEIL = 7'(DUTY_MAX);

    logic                  sck_s, sck_rise, sck_fall;
    logic                  cs_s, cs_rise, cs_fall;
    logic                  sdi_meta, sdi_s;
    rx_state_t             state, state_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic [WDOG_W-1:0]     wdog_cnt;
    logic                  commit;
    logic                  malformed;
    logic                  unused_sync;

    sync_edge_det u_sck_sync (
        .clk  (clk),
        .din  (sck),
        .sync (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    sync_edge_det u_cs_sync (
        .clk  (clk),
        .din  (cs_n),
        .sync (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    assign unused_sync = &{1'b0, sck_s, sck_fall, cs_s};

    // sdi shares the sck pipeline depth so each sampled bit lines up with sck_rise
    always_ff @(posedge clk) begin
        sdi_meta <= sdi;
        sdi_s    <= sdi_meta;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = RECV;
            RECV:    if (cs_rise) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == IDLE && cs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == RECV && sck_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s};
            bit_cnt   <= (bit_cnt == BIT_CNT_SAT) ? bit_cnt : bit_cnt + 5'd1;
        end
    end

    assign commit    = (state == DONE) && (bit_cnt == 5'(FRAME_BITS));
    assign malformed = (state == DONE) && !commit;

    // A commit always beats a watchdog expiry landing in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            motor1_sign       <= 1'b0;
            motor1_upperlimit <= '0;
            motor2_sign       <= 1'b0;
            motor2_upperlimit <= '0;
            load              <= 1'b0;
            frame_error       <= 1'b0;
            wdog_timeout      <= 1'b0;
            wdog_cnt          <= '0;
        end else begin
            load        <= 1'b0;
            frame_error <= malformed;
            if (commit) begin
                motor1_sign       <= shift_reg[M1_SIGN_BIT];
                motor1_upperlimit <= sat_duty(shift_reg[M1_DUTY_MSB:M1_DUTY_LSB], DUTY_CEIL);
                motor2_sign       <= shift_reg[M2_SIGN_BIT];
                motor2_upperlimit <= sat_duty(shift_reg[M2_DUTY_MSB:M2_DUTY_LSB], DUTY_CEIL);
                load              <= 1'b1;
                wdog_timeout      <= 1'b0;
                wdog_cnt          <= '0;
            end else if (wdog_cnt != WDOG_LAST) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end else if (!wdog_timeout) begin
                motor1_upperlimit <= '0;
                motor2_upperlimit <= '0;
                load              <= 1'b1;
                wdog_timeout      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// tb/tb_motor_cmd_spi_rx.sv - self-checking bench for motor_cmd_spi_rx against a frame-level reference model
module tb_motor_cmd_spi_rx;

    localparam int WDOG = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       cs_n;
    logic       sdi;
    logic       motor1_sign;
    logic [6:0] motor1_upperlimit;
    logic       motor2_sign;
    logic [6:0] motor2_upperlimit;
    logic       load;
    logic       frame_error;
    logic       wdog_timeout;
    logic [15:0] outs;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int load_cnt = 0;
    int ferr_cnt = 0;
    int exp_s1, exp_d1, exp_s2, exp_d2, exp_to, last_commit;

    motor_cmd_spi_rx #(
        .DUTY_MAX    (100),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .sck               (sck),
        .cs_n              (cs_n),
        .sdi               (sdi),
        .motor1_sign       (motor1_sign),
        .motor1_upperlimit (motor1_upperlimit),
        .motor2_sign       (motor2_sign),
        .motor2_upperlimit (motor2_upperlimit),
        .load              (load),
        .frame_error       (frame_error),
        .wdog_timeout      (wdog_timeout)
    );

    assign outs = {motor1_sign, motor1_upperlimit, motor2_sign, motor2_upperlimit};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #2;
        if (load) load_cnt++;
        if (frame_error) ferr_cnt++;
    end

    function automatic logic [15:0] model_vec();
        return {1'(exp_s1), 7'(exp_d1), 1'(exp_s2), 7'(exp_d2)};
    endfunction

    task automatic model_reset();
        exp_s1 = 0; exp_d1 = 0; exp_s2 = 0; exp_d2 = 0; exp_to = 0;
        last_commit = cyc;
    endtask

    task automatic model_frame(input logic [31:0] data, input int nbits, input int n);
        int v;
        if (nbits != 16) return;
        v = int'(data[15:0]);
        exp_s1 = v / 32768;
        exp_d1 = (v / 256) % 128;
        exp_s2 = (v / 128) % 2;
        exp_d2 = v % 128;
        if (exp_d1 > 100) exp_d1 = 100;
        if (exp_d2 > 100) exp_d2 = 100;
        exp_to = 0;
        last_commit = n + 4;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_neg(4);
    endtask

    task automatic clock_bits(input logic [31:0] data, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sdi = data[i];
            wait_neg(4);
            sck = 1'b1;
            wait_neg(4);
            sck = 1'b0;
        end
    endtask

    task automatic raise_cs(output int n);
        cs_n = 1'b1;
        n = cyc;
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits, output int n);
        cs_low();
        if (nbits > 0) clock_bits(data, nbits - 1, 0);
        wait_neg(2);
        raise_cs(n);
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
        wait_neg(5);
        checks++;
        if (outs !== 16'h0000) begin failures++; $display("FAIL reset_outs got=%h exp=0000", outs); end
        checks++;
        if ({load, frame_error, wdog_timeout} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {load, frame_error, wdog_timeout});
        end
        reset = 1'b0;
        model_reset();
        wait_neg(3);
        checks++;
        if (load_cnt !== 0 || ferr_cnt !== 0) begin
            failures++; $display("FAIL reset_pulses load=%0d ferr=%0d exp=0/0", load_cnt, ferr_cnt);
        end
    endtask

    task automatic test_basic();
        int n, lc;
        lc = load_cnt;
        cs_low();
        clock_bits(32'h8A32, 15, 0);
        wait_neg(2);
        raise_cs(n);
        model_frame(32'h8A32, 16, n);
        for (int k = 1; k <= 3; k++) begin
            wait_until(n + k);
            checks++;
            if (load !== 1'b0) begin failures++; $display("FAIL basic_early_load k=%0d got=%b exp=0", k, load); end
        end
        wait_until(n + 4);
        checks++;
        if (load !== 1'b1) begin failures++; $display("FAIL basic_load_latency got=%b exp=1", load); end
        checks++;
        if (outs !== 16'h8A32 || outs !== model_vec()) begin
            failures++; $display("FAIL basic_outs got=%h exp=%h", outs, model_vec());
        end
        wait_until(n + 5);
        checks++;
        if (load !== 1'b0) begin failures++; $display("FAIL basic_load_width got=%b exp=0", load); end
        wait_neg(2);
        checks++;
        if (load_cnt !== lc + 1) begin failures++; $display("FAIL basic_load_count got=%0d exp=%0d", load_cnt, lc + 1); end
    endtask

    task automatic test_bad_frames();
        int n, lc, fc, len;
        for (int i = 0; i < 2; i++) begin
            len = (i == 0) ? 12 : 20;
            lc = load_cnt;
            fc = ferr_cnt;
            send_frame($urandom, len, n);
            model_frame(32'h0, len, n);
            wait_until(n + 6);
            checks++;
            if (ferr_cnt !== fc + 1) begin failures++; $display("FAIL bad_ferr len=%0d got=%0d exp=%0d", len, ferr_cnt, fc + 1); end
            checks++;
            if (load_cnt !== lc) begin failures++; $display("FAIL bad_load len=%0d got=%0d exp=%0d", len, load_cnt, lc); end
            checks++;
            if (outs !== 16'h8A32 || wdog_timeout !== 1'(exp_to)) begin
                failures++; $display("FAIL bad_hold len=%0d got=%h/%b exp=8a32/%0d", len, outs, wdog_timeout, exp_to);
            end
        end
    endtask

    task automatic test_saturate();
        int n, lc;
        lc = load_cnt;
        send_frame(32'h7FFF, 16, n);
        model_frame(32'h7FFF, 16, n);
        wait_until(n + 6);
        checks++;
        if (outs !== 16'h64E4 || outs !== model_vec()) begin
            failures++; $display("FAIL sat_outs got=%h exp=%h", outs, model_vec());
        end
        checks++;
        if (load_cnt !== lc + 1) begin failures++; $display("FAIL sat_load got=%0d exp=%0d", load_cnt, lc + 1); end
    endtask

    task automatic test_random();
        int n, lc, fc, nbits;
        bit force_valid = 1'b0;
        logic [31:0] data;
        for (int i = 0; i < 40; i++) begin
            nbits = (force_valid || $urandom_range(0, 3) != 0) ? 16 : int'($urandom_range(0, 24));
            force_valid = (nbits != 16);
            data = $urandom;
            lc = load_cnt;
            fc = ferr_cnt;
            wait_neg($urandom_range(0, 20));
            send_frame(data, nbits, n);
            model_frame(data, nbits, n);
            wait_until(n + 6);
            checks++;
            if (outs !== model_vec() || wdog_timeout !== 1'b0) begin
                failures++; $display("FAIL rand_outs i=%0d data=%h bits=%0d got=%h/%b exp=%h/0", i, data, nbits, outs, wdog_timeout, model_vec());
            end
            checks++;
            if (load_cnt - lc !== int'(nbits == 16) || ferr_cnt - fc !== int'(nbits != 16)) begin
                failures++; $display("FAIL rand_pulses i=%0d bits=%0d load=%0d ferr=%0d", i, nbits, load_cnt - lc, ferr_cnt - fc);
            end
        end
    endtask

    task automatic test_watchdog();
        int n, lc, base;
        base = last_commit;
        wait_until(base + WDOG - 1);
        checks++;
        if (outs !== model_vec() || wdog_timeout !== 1'b0) begin
            failures++; $display("FAIL wdog_early got=%h/%b exp=%h/0", outs, wdog_timeout, model_vec());
        end
        wait_until(base + WDOG);
        exp_d1 = 0; exp_d2 = 0; exp_to = 1;
        checks++;
        if (outs !== model_vec() || wdog_timeout !== 1'b1 || load !== 1'b1) begin
            failures++; $display("FAIL wdog_expire got=%h/%b/%b exp=%h/1/1", outs, wdog_timeout, load, model_vec());
        end
        lc = load_cnt;
        wait_neg(1500);
        checks++;
        if (load_cnt !== lc || wdog_timeout !== 1'b1 || outs !== model_vec()) begin
            failures++; $display("FAIL wdog_hold load=%0d exp=%0d to=%b outs=%h", load_cnt, lc, wdog_timeout, outs);
        end
        send_frame(32'h0505, 16, n);
        model_frame(32'h0505, 16, n);
        wait_until(n + 6);
        checks++;
        if (outs !== 16'h0505 || outs !== model_vec() || wdog_timeout !== 1'b0) begin
            failures++; $display("FAIL wdog_recover got=%h/%b exp=0505/0", outs, wdog_timeout);
        end
    endtask

    task automatic test_reset_midframe();
        int n, lc, fc;
        lc = load_cnt;
        fc = ferr_cnt;
        cs_low();
        clock_bits(32'h8A32, 15, 7);
        reset = 1'b1;
        wait_neg(3);
        reset = 1'b0;
        model_reset();
        clock_bits(32'h8A32, 6, 0);
        wait_neg(2);
        cs_n = 1'b1;
        wait_neg(8);
        checks++;
        if (load_cnt !== lc || ferr_cnt !== fc) begin
            failures++; $display("FAIL midreset_pulses load=%0d ferr=%0d exp=%0d/%0d", load_cnt, ferr_cnt, lc, fc);
        end
        checks++;
        if (outs !== model_vec() || wdog_timeout !== 1'b0) begin
            failures++; $display("FAIL midreset_outs got=%h/%b exp=%h/0", outs, wdog_timeout, model_vec());
        end
        send_frame(32'h8164, 16, n);
        model_frame(32'h8164, 16, n);
        wait_until(n + 6);
        checks++;
        if (outs !== 16'h8164 || outs !== model_vec()) begin
            failures++; $display("FAIL midreset_next got=%h exp=8164", outs);
        end
    endtask

    task automatic test_collision();
        int n, base;
        base = last_commit;
        wait_until(base + 700);
        cs_low();
        clock_bits(32'h1234, 15, 0);
        wait_until(base + WDOG - 4);
        raise_cs(n);
        model_frame(32'h1234, 16, n);
        wait_until(base + WDOG);
        checks++;
        if (load !== 1'b1 || wdog_timeout !== 1'b0 || outs !== 16'h1234 || outs !== model_vec()) begin
            failures++; $display("FAIL collide_commit got=%h/%b/%b exp=1234/load1/to0", outs, load, wdog_timeout);
        end
        wait_until(base + 2 * WDOG - 1);
        checks++;
        if (outs !== model_vec() || wdog_timeout !== 1'b0) begin
            failures++; $display("FAIL collide_restart got=%h/%b exp=%h/0", outs, wdog_timeout, model_vec());
        end
        wait_until(base + 2 * WDOG);
        exp_d1 = 0; exp_d2 = 0; exp_to = 1;
        checks++;
        if (outs !== model_vec() || wdog_timeout !== 1'b1 || load !== 1'b1) begin
            failures++; $display("FAIL collide_next_expire got=%h/%b/%b exp=%h/1/1", outs, wdog_timeout, load, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_frames();
        test_saturate();
        test_random();
        test_watchdog();
        test_reset_midframe();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
